// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - frame constants and sender state encoding shared by the frame sender and receiver
package frame_pkg;
    localparam logic [7:0] FRAME_HEADER = 8'h01;
    localparam int         FRAME_LEN    = 64;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR,
        ST_RD,
        ST_RD_WAIT,
        ST_SEND,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_GAP,
        ST_FIN
    } sender_state_t;
endpackage

// File: rtl/byte_pacer.sv
// rtl/byte_pacer.sv - hands one byte to uart_basic, waits out its busy window plus an optional idle gap
module byte_pacer
    import frame_pkg::*;
#(
    parameter int INTER_BYTE_DELAY = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] byte_in,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       byte_done
);
    localparam int DLY_W = (INTER_BYTE_DELAY > 0) ? $clog2(INTER_BYTE_DELAY + 1) : 1;
    localparam logic [DLY_W-1:0] DLY_LAST =
        (INTER_BYTE_DELAY > 0) ? DLY_W'(INTER_BYTE_DELAY - 1) : '0;

    sender_state_t    state_q;
    logic             tx_start_q;
    logic [7:0]       tx_data_q;
    logic             byte_done_q;
    logic [DLY_W-1:0] dly_q;
    logic [DLY_W-1:0] dly_d;

    assign dly_d = dly_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            byte_done_q <= 1'b0;
            dly_q       <= '0;
        end else begin
            tx_start_q  <= 1'b0;
            byte_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        tx_data_q <= byte_in;
                        state_q   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!tx_busy) begin
                        tx_start_q <= 1'b1;
                        state_q    <= ST_WAIT_HI;
                    end
                end
                // uart_basic may take a few cycles to raise busy; never re-send meanwhile
                ST_WAIT_HI: begin
                    if (tx_busy) begin
                        state_q <= ST_WAIT_LO;
                    end
                end
                ST_WAIT_LO: begin
                    if (!tx_busy) begin
                        if (INTER_BYTE_DELAY == 0) begin
                            byte_done_q <= 1'b1;
                            state_q     <= ST_IDLE;
                        end else begin
                            dly_q   <= '0;
                            state_q <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (dly_q == DLY_LAST) begin
                        byte_done_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        dly_q <= dly_d;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign byte_done = byte_done_q;
endmodule

// File: rtl/bram_uart_sender.sv
// rtl/bram_uart_sender.sv - sends a header byte then NUM_BYTES BRAM bytes through uart_basic
module bram_uart_sender
    import frame_pkg::*;
#(
    parameter int         NUM_BYTES        = FRAME_LEN,
    parameter int         ADDR_W           = 6,
    parameter logic [7:0] HEADER_BYTE      = FRAME_HEADER,
    parameter int         MEM_LATENCY      = 2,
    parameter int         INTER_BYTE_DELAY = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_dout,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic              busy,
    output logic              done
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BYTES - 1);
    localparam logic [1:0]        LAT_LAST  = 2'(MEM_LATENCY - 1);

    sender_state_t     state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;
    logic [1:0]        lat_q;
    logic              hdr_done_q;
    logic              mem_en_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              busy_q;
    logic              done_q;
    logic              load;
    logic [7:0]        byte_in;
    logic              byte_done;

    assign cnt_d   = cnt_q + 1'b1;
    assign load    = (state_q == ST_HDR) || ((state_q == ST_RD_WAIT) && (lat_q == LAT_LAST));
    assign byte_in = (state_q == ST_HDR) ? HEADER_BYTE : mem_dout;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            lat_q      <= '0;
            hdr_done_q <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            mem_en_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cnt_q      <= '0;
                        hdr_done_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_HDR;
                    end
                end
                ST_HDR: state_q <= ST_SEND;
                ST_RD: begin
                    lat_q   <= '0;
                    state_q <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (lat_q == LAT_LAST) begin
                        state_q <= ST_SEND;
                    end else begin
                        lat_q <= lat_q + 2'd1;
                    end
                end
                // the pacer owns the uart handshake; the next-byte decision is taken here
                ST_SEND: begin
                    if (byte_done) begin
                        if (!hdr_done_q) begin
                            hdr_done_q <= 1'b1;
                            mem_en_q   <= 1'b1;
                            mem_addr_q <= cnt_q;
                            state_q    <= ST_RD;
                        end else if (cnt_q == LAST_ADDR) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_FIN;
                        end else begin
                            cnt_q      <= cnt_d;
                            mem_en_q   <= 1'b1;
                            mem_addr_q <= cnt_d;
                            state_q    <= ST_RD;
                        end
                    end
                end
                ST_FIN:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    byte_pacer #(
        .INTER_BYTE_DELAY(INTER_BYTE_DELAY)
    ) u_pacer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .byte_in  (byte_in),
        .tx_busy  (tx_busy),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .byte_done(byte_done)
    );

    assign mem_en   = mem_en_q;
    assign mem_addr = mem_addr_q;
    assign busy     = busy_q;
    assign done     = done_q;
endmodule

// File: doc/bram_uart_sender.md
Name: bram_uart_sender

Overview:
- Transmit-side counterpart of the 64-byte UART frame receiver.
- On a start request, sends header byte HEADER_BYTE, then NUM_BYTES payload bytes read sequentially from a BRAM read port (address 0 upward).
- Drives tx_start/tx_data of uart_basic and paces on tx_busy.
- Sits between the frame BRAM (port B) and uart_basic in the top-level stage.

Parameters:
- NUM_BYTES, 64, payload bytes per frame (2..2**ADDR_W).
- ADDR_W, 6, BRAM address width.
- HEADER_BYTE, 8'h01, first byte of every frame.
- MEM_LATENCY, 2, cycles from mem_addr/mem_en to valid mem_dout (1..3).
- INTER_BYTE_DELAY, 0, idle clk cycles inserted after each byte completes (0 = none).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle frame request; honoured only in IDLE
- mem_en  out  1  BRAM read enable
- mem_addr  out  ADDR_W  BRAM read address
- mem_dout  in  8  BRAM read data
- tx_start  out  1  one-cycle pulse to uart_basic
- tx_data  out  8  byte to uart_basic; stable from the tx_start cycle until tx_busy falls
- tx_busy  in  1  uart_basic transmitter busy
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last payload byte completes

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high: reset sampled high at a clk edge forces the reset state.
- Reset values: state IDLE; mem_en=0, mem_addr=0, tx_start=0, tx_data=0, busy=0, done=0; byte counter and delay counter = 0.
- Reset mid-frame: abort immediately and return to IDLE. Any byte already handed to uart_basic finishes on its own. No done pulse.
- States: IDLE, HDR, RD, RD_WAIT, SEND, WAIT_HI, WAIT_LO, GAP, FIN.
- IDLE:
  - start=1 -> HDR; clear the byte counter; busy=1 from the next cycle.
  - start in any other state is ignored.
- HDR:
  - When tx_busy=0: tx_data<=HEADER_BYTE, tx_start=1 for one cycle -> WAIT_HI.
  - Otherwise wait in HDR.
- RD:
  - mem_en=1, mem_addr=counter for one cycle -> RD_WAIT.
- RD_WAIT:
  - Count MEM_LATENCY cycles.
  - On the last cycle, register mem_dout into tx_data -> SEND.
- SEND:
  - When tx_busy=0: tx_start=1 for one cycle -> WAIT_HI.
- WAIT_HI:
  - Stay until tx_busy=1, then -> WAIT_LO.
  - Prevents double-sending before uart_basic raises busy.
- WAIT_LO:
  - Stay until tx_busy=0.
  - Then -> GAP if INTER_BYTE_DELAY>0; otherwise take the next-byte decision directly.
- GAP:
  - Count INTER_BYTE_DELAY cycles, then take the next-byte decision.
- Next-byte decision:
  - After the header: -> RD with counter=0.
  - After a payload byte with counter==NUM_BYTES-1: -> FIN.
  - Otherwise: counter+1 -> RD.
- FIN:
  - done=1 for exactly one cycle, busy=0, -> IDLE.
  - start in this cycle is ignored.
- Counter:
  - ADDR_W bits; compared against NUM_BYTES-1, so the address never wraps.
  - With NUM_BYTES=2**ADDR_W the last address is all-ones and the counter is not incremented past it.
- Delay counter: width $clog2(INTER_BYTE_DELAY+1), minimum 1.
- tx_start is never asserted while tx_busy=1.
- Exactly NUM_BYTES+1 tx_start pulses per completed frame.
- mem_en is high only in RD. No writes to the BRAM from this block.

Decomposition:
- Package frame_pkg:
  - state enum sender_state_t.
  - Constants FRAME_HEADER=8'h01 and FRAME_LEN=64.
  - The receiver uses the same package.
- One sub-module is natural: byte_pacer. It owns the SEND/WAIT_HI/WAIT_LO/GAP handshake and delay counter. It has a load/byte_in input and a byte_done output.
- The parent FSM handles header, addressing and framing.

Test Plan:
- BRAM model preloaded with mem[i]=i+8'h10, MEM_LATENCY=2, UART model raising tx_busy 1 cycle after tx_start and holding it 20 cycles; pulse start -> tx_data sequence 0x01, 0x10..0x4F (65 bytes), then one done pulse; busy high throughout.
- start pulsed again mid-frame (at byte 10) -> ignored; byte count stays 65; no extra tx_start.
- tx_busy already high when start arrives, held 50 cycles -> header tx_start not issued until tx_busy=0.
- UART model delays tx_busy rise by 5 cycles -> still exactly one tx_start per byte; no byte skipped or repeated.
- reset asserted at byte 30 -> next cycle state IDLE, tx_start=0, busy=0, mem_en=0, no done; a fresh start then sends a full 65-byte frame from address 0.
- INTER_BYTE_DELAY=100, MEM_LATENCY=1, NUM_BYTES=4 -> ≥100 cycles between each tx_busy fall and the next tx_start; last mem_addr=3; done once.
